// File: rtl/hoplite_pkg.sv
// Shared Hoplite flit field definitions: destination coordinate layout and the
// local-address match used by the injection queue and ROUTER.
package hoplite_pkg;

  localparam int CNT_WIDTH_DEFAULT = 32;

  // Widest coordinate supported by dst_match; the caller zero-pads the field.
  localparam int MAX_ADDR_W = 8;

  // Field index inside the destination slice; bit offset = index * ADDRESS_WIDTH.
  localparam int X_FIELD = 0;
  localparam int Y_FIELD = 1;
  localparam int Z_FIELD = 2;

  function automatic logic dst_match(input logic [3*MAX_ADDR_W-1:0] flit_dst,
                                     input int cx, input int cy, input int cz,
                                     input int aw);
    logic [31:0] d;
    logic [31:0] mask;
    d    = {8'd0, flit_dst};
    mask = (32'd1 << aw) - 32'd1;
    return (((d >> (X_FIELD * aw)) & mask) == (32'(cx) & mask)) &&
           (((d >> (Y_FIELD * aw)) & mask) == (32'(cy) & mask)) &&
           (((d >> (Z_FIELD * aw)) & mask) == (32'(cz) & mask));
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// Circular flit buffer with a combinational head read; occupancy is tracked
// separately from the pointers so full and empty never alias.
module flit_fifo #(
  parameter  int FLIT_SIZE = 128,
  parameter  int DEPTH     = 8,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [FLIT_SIZE-1:0] push_data,
  input  logic                 pop,
  output logic [FLIT_SIZE-1:0] head,
  output logic [LVL_W-1:0]     level,
  output logic                 full,
  output logic                 empty
);

  logic [FLIT_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg;
  logic [PTR_W-1:0]     rd_ptr_reg;
  logic [LVL_W-1:0]     level_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign level = level_reg;
  assign full  = (level_reg == LVL_W'(DEPTH));
  assign empty = (level_reg == '0);

endmodule

// File: rtl/pe_injection_queue.sv
// PE-side injection queue for a Hoplite node: offers the head flit to ROUTER
// until accepted, diverts self-addressed flits to a local eject port.
module pe_injection_queue
  import hoplite_pkg::*;
#(
  parameter int FLIT_SIZE     = 128,
  parameter int ADDRESS_WIDTH = 3,
  parameter int CUR_X         = 0,
  parameter int CUR_Y         = 0,
  parameter int CUR_Z         = 0,
  parameter int DEPTH         = 8,
  parameter int CNT_WIDTH     = CNT_WIDTH_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pe_wr_valid,
  input  logic [FLIT_SIZE-1:0]       pe_wr_data,
  output logic                       pe_wr_ready,
  output logic                       pe_in_valid,
  output logic [FLIT_SIZE-1:0]       pe_input,
  input  logic                       injection_success,
  output logic                       local_eject_valid,
  output logic [FLIT_SIZE-1:0]       local_eject,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_WIDTH-1:0]       inj_count,
  output logic [CNT_WIDTH-1:0]       stall_count,
  output logic                       protocol_err
);

  logic [FLIT_SIZE-1:0]      head;
  logic                      full;
  logic                      empty;
  logic                      push;
  logic                      pop;
  logic                      net_pop;
  logic                      local_pop;
  logic                      head_local;
  logic [3*MAX_ADDR_W-1:0]   dst_field;

  logic                      eject_valid_reg;
  logic [FLIT_SIZE-1:0]      eject_data_reg;
  logic [CNT_WIDTH-1:0]      inj_count_reg;
  logic [CNT_WIDTH-1:0]      stall_count_reg;
  logic                      protocol_err_reg;

  flit_fifo #(
    .FLIT_SIZE (FLIT_SIZE),
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (pe_wr_data),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    dst_field = '0;
    dst_field[3*ADDRESS_WIDTH-1:0] = head[3*ADDRESS_WIDTH-1:0];
  end

  assign head_local  = dst_match(dst_field, CUR_X, CUR_Y, CUR_Z, ADDRESS_WIDTH);
  // Full refuses writes outright, even if a pop frees a slot this cycle.
  assign push        = pe_wr_valid && !full;
  assign pe_in_valid = !empty && !head_local;
  assign net_pop     = pe_in_valid && injection_success;
  assign local_pop   = !empty && head_local;
  assign pop         = net_pop || local_pop;

  assign pe_wr_ready = !full;
  assign pe_input    = head;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eject_valid_reg  <= 1'b0;
      eject_data_reg   <= '0;
      inj_count_reg    <= '0;
      stall_count_reg  <= '0;
      protocol_err_reg <= 1'b0;
    end else begin
      eject_valid_reg <= local_pop;
      if (local_pop) eject_data_reg <= head;
      if (net_pop && (inj_count_reg != '1))
        inj_count_reg <= inj_count_reg + CNT_WIDTH'(1);
      if (pe_in_valid && !injection_success && (stall_count_reg != '1))
        stall_count_reg <= stall_count_reg + CNT_WIDTH'(1);
      // A success with nothing offered is a router protocol violation.
      if (injection_success && !pe_in_valid)
        protocol_err_reg <= 1'b1;
    end
  end

  assign local_eject_valid = eject_valid_reg;
  assign local_eject       = eject_data_reg;
  assign inj_count         = inj_count_reg;
  assign stall_count       = stall_count_reg;
  assign protocol_err      = protocol_err_reg;

endmodule

// File: tb/tb_pe_injection_queue.sv
// Directed plus random bench for pe_injection_queue, compared cycle by cycle
// against a queue-based reference model.
module tb_pe_injection_queue;

  localparam int FLIT  = 128;
  localparam int DEPTH = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            pe_wr_valid = 1'b0;
  logic [FLIT-1:0] pe_wr_data = '0;
  logic            pe_wr_ready;
  logic            pe_in_valid;
  logic [FLIT-1:0] pe_input;
  logic            injection_success = 1'b0;
  logic            local_eject_valid;
  logic [FLIT-1:0] local_eject;
  logic [3:0]      level;
  logic [31:0]     inj_count;
  logic [31:0]     stall_count;
  logic            protocol_err;

  pe_injection_queue dut (
    .clk               (clk),
    .rst               (rst),
    .pe_wr_valid       (pe_wr_valid),
    .pe_wr_data        (pe_wr_data),
    .pe_wr_ready       (pe_wr_ready),
    .pe_in_valid       (pe_in_valid),
    .pe_input          (pe_input),
    .injection_success (injection_success),
    .local_eject_valid (local_eject_valid),
    .local_eject       (local_eject),
    .level             (level),
    .inj_count         (inj_count),
    .stall_count       (stall_count),
    .protocol_err      (protocol_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [FLIT-1:0] mq[$];
  logic [31:0]     m_inj = 0;
  logic [31:0]     m_stall = 0;
  logic            m_err = 1'b0;
  logic            m_ej_valid = 1'b0;
  logic [FLIT-1:0] m_ej_data = '0;

  task automatic chk(input string name, input logic [FLIT-1:0] act, input logic [FLIT-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_local(input logic [FLIT-1:0] f);
    return (f[2:0] == 3'd0) && (f[5:3] == 3'd0) && (f[8:6] == 3'd0);
  endfunction

  // Monitor: compares DUT against the model, then advances the model by the
  // inputs that will be applied at the coming rising edge.
  always @(negedge clk) begin
    logic hv;
    logic [FLIT-1:0] hd;
    if (!rst) begin
      mq.delete();
      m_inj = 0; m_stall = 0; m_err = 1'b0; m_ej_valid = 1'b0; m_ej_data = '0;
      chk("rst_level", FLIT'(level), '0);
      chk("rst_wr_ready", FLIT'(pe_wr_ready), FLIT'(1));
      chk("rst_in_valid", FLIT'(pe_in_valid), '0);
      chk("rst_eject_valid", FLIT'(local_eject_valid), '0);
      chk("rst_eject", local_eject, '0);
      chk("rst_inj_count", FLIT'(inj_count), '0);
      chk("rst_stall_count", FLIT'(stall_count), '0);
      chk("rst_protocol_err", FLIT'(protocol_err), '0);
    end else begin
      hd = (mq.size() > 0) ? mq[0] : '0;
      hv = (mq.size() > 0) && !is_local(hd);
      chk("level", FLIT'(level), FLIT'(mq.size()));
      chk("wr_ready", FLIT'(pe_wr_ready), FLIT'(mq.size() < DEPTH));
      chk("in_valid", FLIT'(pe_in_valid), FLIT'(hv));
      if (hv) chk("pe_input", pe_input, hd);
      chk("eject_valid", FLIT'(local_eject_valid), FLIT'(m_ej_valid));
      chk("eject_data", local_eject, m_ej_data);
      chk("inj_count", FLIT'(inj_count), FLIT'(m_inj));
      chk("stall_count", FLIT'(stall_count), FLIT'(m_stall));
      chk("protocol_err", FLIT'(protocol_err), FLIT'(m_err));

      m_ej_valid = 1'b0;
      if (m_ej_valid === 1'b0 && local_eject_valid) ; // data already compared above
      if (hv && injection_success) begin
        $display("inject %h level=%0d", hd, mq.size());
        void'(mq.pop_front());
        if (m_inj != 32'hFFFF_FFFF) m_inj++;
      end else if (hv) begin
        if (m_stall != 32'hFFFF_FFFF) m_stall++;
      end else if (mq.size() > 0) begin
        $display("local eject %h level=%0d", hd, mq.size());
        void'(mq.pop_front());
        m_ej_valid = 1'b1;
        m_ej_data  = hd;
      end
      if (injection_success && !hv) m_err = 1'b1;
      // Occupancy before this edge's pop decides acceptance.
      if (pe_wr_valid && (mq.size() + ((hv && injection_success) || (!hv && mq.size() > 0) ? 1 : 0) < DEPTH)) begin
        mq.push_back(pe_wr_data);
        $display("write %h accepted", pe_wr_data);
      end else if (pe_wr_valid) begin
        $display("write %h refused", pe_wr_data);
      end
    end
  end

  task automatic cyc(input logic v, input logic [FLIT-1:0] d, input logic s);
    @(posedge clk); #1;
    pe_wr_valid = v; pe_wr_data = d; injection_success = s;
  endtask

  function automatic logic [FLIT-1:0] rnd_flit();
    logic [FLIT-1:0] f;
    f = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 3) == 0) f[8:0] = 9'd0;
    return f;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [FLIT-1:0] a, l, r;
    a = {119'd1, 3'd1, 3'd1, 3'd1};
    l = {119'd7, 3'd0, 3'd0, 3'd0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Single flit, always accepted
    cyc(1'b1, a, 1'b1);
    cyc(1'b0, '0, 1'b0);
    repeat (3) cyc(1'b0, '0, 1'b0);

    // Held for five stall cycles, then accepted
    cyc(1'b1, a, 1'b0);
    repeat (5) cyc(1'b0, '0, 1'b0);
    cyc(1'b0, '0, 1'b1);
    repeat (2) cyc(1'b0, '0, 1'b0);

    // Fill to full, ninth write refused, then drain in order
    for (int i = 0; i < 9; i++) cyc(1'b1, {FLIT'(i + 100), 9'h049}, 1'b0);
    cyc(1'b0, '0, 1'b0);
    repeat (10) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Local flit sandwiched between remote ones
    r = {119'd55, 3'd2, 3'd1, 3'd3};
    cyc(1'b1, r, 1'b1);
    cyc(1'b1, l, 1'b1);
    cyc(1'b1, a, 1'b1);
    repeat (5) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);

    // Stray success while empty
    cyc(1'b0, '0, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0);

    // Asynchronous reset with five flits queued
    for (int i = 0; i < 5; i++) cyc(1'b1, {FLIT'(i + 200), 9'h092}, 1'b0);
    cyc(1'b0, '0, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("async_rst_level", FLIT'(level), '0);
    chk("async_rst_in_valid", FLIT'(pe_in_valid), '0);
    chk("async_rst_wr_ready", FLIT'(pe_wr_ready), FLIT'(1));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    cyc(1'b1, a, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 3) != 0, rnd_flit(), 1'($urandom_range(0, 1)));
    repeat (12) cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
